mem_tx_streamer: RTL and testbench

Reads a contiguous, wrap-around run of 32-bit registers out of the channel's register-file memory through its read port and sends them to the host as one RIFFA TX channel transaction, packing two words per 64-bit beat. It sits beside the register file on the 64-bit RIFFA channel. The RX-side writer fills the memory. This block drains it back to the host on a `start` request.

---
 rtl/mem_tx_streamer_pkg.sv | 25 ++
 rtl/mem_tx_streamer_if.sv | 36 +++
 rtl/mem_tx_streamer.sv | 148 ++++++++++++++
 tb/tb_mem_tx_streamer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_tx_streamer_pkg.sv
// Shared types and constants for the register-file TX streamer.
package mem_tx_pkg;

  // Streamer sequencing: request the channel, read low word, read high word, send beat.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    LO   = 3'd2,
    HI   = 3'd3,
    SEND = 3'd4
  } mem_tx_state_t;

  // Offset at which the register file is mapped on the read port.
  localparam int BASE_ADDR = 6;

  // Width of the register-file read address.
  localparam int RD_ADDR_W = 7;

  // Width of a RIFFA channel data beat.
  localparam int BEAT_W = 64;

  // Width of one register-file word.
  localparam int WORD_W = 32;

endpackage

// File: rtl/mem_tx_streamer_if.sv
// RIFFA TX channel bundle (64-bit data path). The streamer is the master,
// the host side is the slave.
interface mem_tx_streamer_if;

  logic        CHNL_TX;
  logic        CHNL_TX_ACK;
  logic        CHNL_TX_LAST;
  logic [31:0] CHNL_TX_LEN;
  logic [30:0] CHNL_TX_OFF;
  logic [63:0] CHNL_TX_DATA;
  logic        CHNL_TX_DATA_VALID;
  logic        CHNL_TX_DATA_REN;

  modport master (
    output CHNL_TX,
    input  CHNL_TX_ACK,
    output CHNL_TX_LAST,
    output CHNL_TX_LEN,
    output CHNL_TX_OFF,
    output CHNL_TX_DATA,
    output CHNL_TX_DATA_VALID,
    input  CHNL_TX_DATA_REN
  );

  modport slave (
    input  CHNL_TX,
    output CHNL_TX_ACK,
    input  CHNL_TX_LAST,
    input  CHNL_TX_LEN,
    input  CHNL_TX_OFF,
    input  CHNL_TX_DATA,
    input  CHNL_TX_DATA_VALID,
    output CHNL_TX_DATA_REN
  );

endinterface

// File: rtl/mem_tx_streamer.sv
// Drains a wrap-around run of 32-bit registers from the register file and
// sends it to the host as one RIFFA TX transaction, two words per 64-bit beat.
// Each beat takes a low-word read cycle, a high-word read cycle and a send
// cycle; an odd final word is sent alone with the upper half zeroed.
module mem_tx_streamer #(
  parameter int NUM_REGS  = 32,
  parameter int IDX_W     = 5,
  parameter int BASE_ADDR = mem_tx_pkg::BASE_ADDR
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [IDX_W-1:0]            start_idx,
  input  logic [IDX_W:0]              count,
  output logic                        busy,
  output logic                        done,
  output logic [mem_tx_pkg::RD_ADDR_W-1:0] rd_addr,
  input  logic [31:0]                 rd_data,
  mem_tx_streamer_if.master           tx
);

  import mem_tx_pkg::*;

  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_REGS - 1);
  localparam logic [RD_ADDR_W-1:0] ADDR_OFFS = RD_ADDR_W'(BASE_ADDR);

  mem_tx_state_t       r_state;
  logic [IDX_W-1:0]    r_cur_idx;
  logic [IDX_W:0]      r_remain;
  logic [31:0]         r_len;
  logic [WORD_W-1:0]   r_beat_lo;
  logic [BEAT_W-1:0]   r_data;
  logic                r_valid;
  logic                r_tx;
  logic                r_busy;
  logic                r_done;

  logic [IDX_W-1:0]    w_next_idx;
  logic                w_accept;

  // Index advance with explicit wrap so NUM_REGS need not fill IDX_W exactly.
  assign w_next_idx = (r_cur_idx == LAST_IDX) ? {IDX_W{1'b0}} : (r_cur_idx + {{(IDX_W-1){1'b0}}, 1'b1});

  // A zero-length request is dropped; the done cycle also refuses a new start
  // so busy is seen low for at least one cycle between transactions.
  assign w_accept = start && (count != {(IDX_W+1){1'b0}}) && !r_done;

  // Read address is the registered index plus the fixed mapping offset.
  assign rd_addr = {{(RD_ADDR_W-IDX_W){1'b0}}, r_cur_idx} + ADDR_OFFS;

  assign busy                  = r_busy;
  assign done                  = r_done;
  assign tx.CHNL_TX            = r_tx;
  assign tx.CHNL_TX_LAST       = r_tx;
  assign tx.CHNL_TX_LEN        = r_len;
  assign tx.CHNL_TX_OFF        = 31'd0;
  assign tx.CHNL_TX_DATA       = r_data;
  assign tx.CHNL_TX_DATA_VALID = r_valid;

  // Transaction sequencer; every channel output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cur_idx <= {IDX_W{1'b0}};
      r_remain  <= {(IDX_W+1){1'b0}};
      r_len     <= 32'd0;
      r_beat_lo <= 32'd0;
      r_data    <= 64'd0;
      r_valid   <= 1'b0;
      r_tx      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cur_idx <= start_idx;
            r_remain  <= count;
            r_len     <= {{(32-IDX_W-1){1'b0}}, count};
            r_tx      <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= REQ;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end

        REQ: begin
          if (tx.CHNL_TX_ACK) begin
            r_state <= LO;
          end else begin
            r_state <= REQ;
          end
        end

        LO: begin
          r_beat_lo <= rd_data;
          r_cur_idx <= w_next_idx;
          r_remain  <= r_remain - {{IDX_W{1'b0}}, 1'b1};
          if (r_remain == {{IDX_W{1'b0}}, 1'b1}) begin
            // Odd tail: ship the lone word with a zero upper half.
            r_data  <= {32'd0, rd_data};
            r_valid <= 1'b1;
            r_state <= SEND;
          end else begin
            r_state <= HI;
          end
        end

        HI: begin
          r_data    <= {rd_data, r_beat_lo};
          r_valid   <= 1'b1;
          r_cur_idx <= w_next_idx;
          r_remain  <= r_remain - {{IDX_W{1'b0}}, 1'b1};
          r_state   <= SEND;
        end

        SEND: begin
          if (tx.CHNL_TX_DATA_REN) begin
            r_valid <= 1'b0;
            if (r_remain != {(IDX_W+1){1'b0}}) begin
              r_state <= LO;
            end else begin
              // Last beat consumed: release the channel and flag completion.
              r_tx    <= 1'b0;
              r_len   <= 32'd0;
              r_done  <= 1'b1;
              r_state <= IDLE;
            end
          end else begin
            r_state <= SEND;
          end
        end

        default: begin
          r_valid <= 1'b0;
          r_tx    <= 1'b0;
          r_len   <= 32'd0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_tx_streamer.sv
// Directed self-checking bench for mem_tx_streamer.
module tb_mem_tx_streamer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  start_idx;
  logic [5:0]  count;
  logic        busy;
  logic        done;
  logic [6:0]  rd_addr;
  logic [31:0] rd_data;
  logic [6:0]  w_rd_off;

  logic [31:0] rf [0:31];

  int total;
  int bad;
  int n_done;
  int d0;

  mem_tx_streamer_if u_if ();

  mem_tx_streamer #(
    .NUM_REGS (32),
    .IDX_W    (5),
    .BASE_ADDR(6)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .start_idx(start_idx),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .tx       (u_if.master)
  );

  // Register-file read port model: rf[rd_addr - 6], garbage outside the map.
  assign w_rd_off = rd_addr - 7'd6;
  assign rd_data  = (rd_addr >= 7'd6 && rd_addr <= 7'd37) ? rf[w_rd_off[4:0]] : 32'hBAD0_BAD0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock; sample/drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (done === 1'b1) n_done++;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      step();
      k++;
    end
    chk("done_wait", {63'd0, done}, 64'd1);
  endtask

  initial begin
    total = 0; bad = 0; n_done = 0;
    rst_n = 1'b0; start = 1'b0; start_idx = 5'd0; count = 6'd0;
    u_if.CHNL_TX_ACK = 1'b0; u_if.CHNL_TX_DATA_REN = 1'b0;
    for (int k = 0; k < 32; k++) rf[k] = 32'h0000_0141;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Reset state
    chk("rst_busy",  {63'd0, busy}, 64'd0);
    chk("rst_done",  {63'd0, done}, 64'd0);
    chk("rst_tx",    {63'd0, u_if.CHNL_TX}, 64'd0);
    chk("rst_valid", {63'd0, u_if.CHNL_TX_DATA_VALID}, 64'd0);
    chk("rst_data",  u_if.CHNL_TX_DATA, 64'd0);
    chk("rst_len",   {32'd0, u_if.CHNL_TX_LEN}, 64'd0);
    chk("rst_raddr", {57'd0, rd_addr}, 64'd6);

    // Full default dump: idx 0, count 4, ACK/REN always high
    u_if.CHNL_TX_ACK = 1'b1; u_if.CHNL_TX_DATA_REN = 1'b1;
    start = 1'b1; start_idx = 5'd0; count = 6'd4;
    step();
    start = 1'b0;
    chk("t1_busy", {63'd0, busy}, 64'd1);
    chk("t1_tx",   {63'd0, u_if.CHNL_TX}, 64'd1);
    chk("t1_last", {63'd0, u_if.CHNL_TX_LAST}, 64'd1);
    chk("t1_len",  {32'd0, u_if.CHNL_TX_LEN}, 64'd4);
    chk("t1_off",  {33'd0, u_if.CHNL_TX_OFF}, 64'd0);
    step(); chk("t1_ra0", {57'd0, rd_addr}, 64'd6);
    step(); chk("t1_ra1", {57'd0, rd_addr}, 64'd7);
    step(); chk("t1_v0", {63'd0, u_if.CHNL_TX_DATA_VALID}, 64'd1);
            chk("t1_d0", u_if.CHNL_TX_DATA, 64'h0000_0141_0000_0141);
    step(); chk("t1_ra2", {57'd0, rd_addr}, 64'd8);
            chk("t1_v0off", {63'd0, u_if.CHNL_TX_DATA_VALID}, 64'd0);
    step(); chk("t1_ra3", {57'd0, rd_addr}, 64'd9);
    step(); chk("t1_v1", {63'd0, u_if.CHNL_TX_DATA_VALID}, 64'd1);
            chk("t1_d1", u_if.CHNL_TX_DATA, 64'h0000_0141_0000_0141);
    step(); chk("t1_done", {63'd0, done}, 64'd1);
            chk("t1_busy_done", {63'd0, busy}, 64'd1);
            chk("t1_txoff", {63'd0, u_if.CHNL_TX}, 64'd0);
            chk("t1_voff", {63'd0, u_if.CHNL_TX_DATA_VALID}, 64'd0);
    step(); chk("t1_done_pulse", {63'd0, done}, 64'd0);
            chk("t1_idle", {63'd0, busy}, 64'd0);

    // Odd count with wrap: rf[k]=k, idx 30, count 3
    for (int k = 0; k < 32; k++) rf[k] = k;
    start = 1'b1; start_idx = 5'd30; count = 6'd3;
    step();
    start = 1'b0;
    chk("t2_len", {32'd0, u_if.CHNL_TX_LEN}, 64'd3);
    step(); chk("t2_ra0", {57'd0, rd_addr}, 64'd36);
    step(); chk("t2_ra1", {57'd0, rd_addr}, 64'd37);
    step(); chk("t2_d0", u_if.CHNL_TX_DATA, 64'h0000_001F_0000_001E);
    step(); chk("t2_ra2", {57'd0, rd_addr}, 64'd6);
    step(); chk("t2_v1", {63'd0, u_if.CHNL_TX_DATA_VALID}, 64'd1);
            chk("t2_d1", u_if.CHNL_TX_DATA, 64'h0000_0000_0000_0000);
    step(); chk("t2_done", {63'd0, done}, 64'd1);
    step();

    // Backpressure: idx 4, count 3, REN low for 5 SEND cycles
    u_if.CHNL_TX_DATA_REN = 1'b0;
    start = 1'b1; start_idx = 5'd4; count = 6'd3;
    step();
    start = 1'b0;
    step(); step(); step();
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", {63'd0, u_if.CHNL_TX_DATA_VALID}, 64'd1);
      chk("bp_data",  u_if.CHNL_TX_DATA, 64'h0000_0005_0000_0004);
      chk("bp_raddr", {57'd0, rd_addr}, 64'd12);
      if (k < 4) step();
    end
    u_if.CHNL_TX_DATA_REN = 1'b1;
    step(); chk("bp_lo", {63'd0, u_if.CHNL_TX_DATA_VALID}, 64'd0);
            chk("bp_ra", {57'd0, rd_addr}, 64'd12);
    step(); chk("bp_d1", u_if.CHNL_TX_DATA, 64'h0000_0000_0000_0006);
            chk("bp_v1", {63'd0, u_if.CHNL_TX_DATA_VALID}, 64'd1);
    step(); chk("bp_done", {63'd0, done}, 64'd1);
    step();

    // Ignored requests: count 0
    start = 1'b1; start_idx = 5'd3; count = 6'd0;
    step();
    start = 1'b0;
    chk("z_busy", {63'd0, busy}, 64'd0);
    chk("z_tx",   {63'd0, u_if.CHNL_TX}, 64'd0);
    d0 = n_done;
    step(); step();
    chk("z_nodone", n_done - d0, 64'd0);

    // Second start while busy with a different count
    u_if.CHNL_TX_ACK = 1'b0;
    start = 1'b1; start_idx = 5'd0; count = 6'd2;
    step();
    count = 6'd5;
    chk("s2_busy", {63'd0, busy}, 64'd1);
    step();
    start = 1'b0; count = 6'd0;
    chk("s2_len", {32'd0, u_if.CHNL_TX_LEN}, 64'd2);
    u_if.CHNL_TX_ACK = 1'b1;
    d0 = n_done;
    repeat (12) step();
    chk("s2_onedone", n_done - d0, 64'd1);
    chk("s2_idle", {63'd0, busy}, 64'd0);

    // ACK delayed 10 cycles
    u_if.CHNL_TX_ACK = 1'b0;
    start = 1'b1; start_idx = 5'd0; count = 6'd2;
    step();
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("aw_tx",    {63'd0, u_if.CHNL_TX}, 64'd1);
      chk("aw_valid", {63'd0, u_if.CHNL_TX_DATA_VALID}, 64'd0);
      step();
    end
    u_if.CHNL_TX_ACK = 1'b1;
    step(); chk("aw_v1", {63'd0, u_if.CHNL_TX_DATA_VALID}, 64'd0);
    u_if.CHNL_TX_ACK = 1'b0;
    step(); chk("aw_v2", {63'd0, u_if.CHNL_TX_DATA_VALID}, 64'd0);
    step(); chk("aw_v3", {63'd0, u_if.CHNL_TX_DATA_VALID}, 64'd1);
            chk("aw_d",  u_if.CHNL_TX_DATA, 64'h0000_0001_0000_0000);
    wait_done(10);
    step();

    // Reset mid-SEND during beat 2 of 4
    u_if.CHNL_TX_ACK = 1'b1; u_if.CHNL_TX_DATA_REN = 1'b1;
    start = 1'b1; start_idx = 5'd0; count = 6'd4;
    step();
    start = 1'b0;
    step(); step(); step();
    step();
    u_if.CHNL_TX_DATA_REN = 1'b0;
    step(); step();
    chk("mr_v2", {63'd0, u_if.CHNL_TX_DATA_VALID}, 64'd1);
    chk("mr_d2", u_if.CHNL_TX_DATA, 64'h0000_0003_0000_0002);
    d0 = n_done;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_busy",  {63'd0, busy}, 64'd0);
    chk("mr_done",  {63'd0, done}, 64'd0);
    chk("mr_tx",    {63'd0, u_if.CHNL_TX}, 64'd0);
    chk("mr_valid", {63'd0, u_if.CHNL_TX_DATA_VALID}, 64'd0);
    chk("mr_data",  u_if.CHNL_TX_DATA, 64'd0);
    chk("mr_len",   {32'd0, u_if.CHNL_TX_LEN}, 64'd0);
    chk("mr_raddr", {57'd0, rd_addr}, 64'd6);
    step(); step();
    rst_n = 1'b1;
    u_if.CHNL_TX_DATA_REN = 1'b1;
    step();
    chk("mr_nodone", n_done - d0, 64'd0);

    // Fresh start after reset: single word at idx 5
    start = 1'b1; start_idx = 5'd5; count = 6'd1;
    step();
    start = 1'b0;
    chk("fr_busy", {63'd0, busy}, 64'd1);
    chk("fr_len",  {32'd0, u_if.CHNL_TX_LEN}, 64'd1);
    step(); chk("fr_ra", {57'd0, rd_addr}, 64'd11);
    step(); chk("fr_v", {63'd0, u_if.CHNL_TX_DATA_VALID}, 64'd1);
            chk("fr_d", u_if.CHNL_TX_DATA, 64'h0000_0000_0000_0005);
    step(); chk("fr_done", {63'd0, done}, 64'd1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
